// File: rtl/tx_arb_pkg.sv
// Shared types and widths for the UART TX FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      GAP,
      HOLD
   } state_e;

   localparam int BYTE_W      = 8;
   localparam int BURST_CNT_W = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after ptr_i, cyclic.
// Purely combinational so the priority rule can be tested on its own.
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IW-1:0]      win_idx_o,
   output logic               valid_o
);

   // Scan from the pointer upward, wrapping once, and keep the first hit.
   always_comb begin : pick
      logic          found;
      logic [IW:0]   s;
      found     = 1'b0;
      s         = '0;
      win_oh_o  = '0;
      win_idx_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         s = {1'b0, ptr_i} + (IW+1)'(k);
         if (s >= (IW+1)'(NUM_REQ)) begin
            s = s - (IW+1)'(NUM_REQ);
         end
         if (!found && req_i[s[IW-1:0]]) begin
            found                 = 1'b1;
            win_idx_o             = s[IW-1:0];
            win_oh_o[s[IW-1:0]]   = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Round-robin, burst-granular arbiter for the UART TX FIFO write port.
// Every byte becomes a one-cycle write_en pulse followed by a low cycle.
module tx_fifo_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        ack_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_write_en_o,
   output logic [BYTE_W-1:0]         fifo_data_in_o
);

   localparam int IW = idx_w(NUM_REQ);
   localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);
   localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_REQ - 1);

   state_e                 state_q, state_d;
   logic [IW-1:0]          rr_q, rr_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [BURST_CNT_W-1:0] burst_q, burst_d;
   logic                   last_q, last_d;
   logic                   wen_q, wen_d;
   logic [BYTE_W-1:0]      data_q, data_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;

   logic [NUM_REQ-1:0]     win_oh;
   logic [IW-1:0]          win_idx;
   logic                   win_vld;

   logic [IW-1:0]          src_idx;
   logic [BYTE_W-1:0]      src_byte;
   logic                   src_last;
   logic [NUM_REQ-1:0]     src_oh;
   logic                   own_req;
   logic                   more;
   logic                   load;
   logic                   start;
   logic                   rel;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i     (req_i),
      .ptr_i     (rr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .valid_o   (win_vld)
   );

   // In IDLE the byte comes from the new winner, otherwise from the owner.
   assign src_idx = (state_q == IDLE) ? win_idx : owner_q;
   assign own_req = req_i[owner_q];
   assign more    = own_req && !last_q && (burst_q < BURST_MAX);

   // Mux out the selected requester's byte, last flag and one-hot.
   always_comb begin
      src_byte = '0;
      src_last = 1'b0;
      src_oh   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_idx == IW'(i)) begin
            src_byte  = req_data_i[i*BYTE_W +: BYTE_W];
            src_last  = req_last_i[i];
            src_oh[i] = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: WRITE and GAP are single cycles; HOLD waits out full.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld && !fifo_full_i) state_d = WRITE;
         end
         WRITE: begin
            state_d = GAP;
         end
         GAP: begin
            if (more && !fifo_full_i) state_d = WRITE;
            else if (more)            state_d = HOLD;
            else                      state_d = IDLE;
         end
         HOLD: begin
            if (!own_req)          state_d = IDLE;
            else if (!fifo_full_i) state_d = WRITE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output/datapath next values; a byte is captured on entry to WRITE.
   always_comb begin
      load    = (state_q != WRITE) && (state_d == WRITE);
      start   = (state_q == IDLE) && load;
      rel     = (state_q != IDLE) && (state_d == IDLE);
      wen_d   = load;
      ack_d   = load ? src_oh : '0;
      data_d  = load ? src_byte : data_q;
      last_d  = load ? src_last : last_q;
      owner_d = start ? win_idx : owner_q;
      grant_d = grant_q;
      if (start)    grant_d = win_oh;
      else if (rel) grant_d = '0;
      burst_d = burst_q;
      if (start)     burst_d = BURST_CNT_W'(1);
      else if (load) burst_d = burst_q + 1'b1;
      rr_d = rr_q;
      if (rel) rr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q    <= '0;
         owner_q <= '0;
         burst_q <= '0;
         last_q  <= 1'b0;
         wen_q   <= 1'b0;
         data_q  <= '0;
         ack_q   <= '0;
         grant_q <= '0;
      end else begin
         rr_q    <= rr_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         wen_q   <= wen_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
      end
   end

   assign ack_o           = ack_q;
   assign grant_o         = grant_q;
   assign busy_o          = (state_q != IDLE);
   assign fifo_write_en_o = wen_q;
   assign fifo_data_in_o  = data_q;

endmodule
